// File: rtl/bk_sub_pipe_if.sv
// Operand/result stream bundle for the Brent-Kung subtractor; valid/ready on both sides.
interface bk_sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             eq;
  logic             lt_s;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, eq, lt_s
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, eq, lt_s
  );
endinterface

// File: rtl/bk_sub_pipe.sv
// Pipelined Brent-Kung subtractor/comparator: diff = a + ~b + 1, 3-cycle latency, 1/cycle.
// Full backpressure, bubbles collapse; in_ready is combinational from out_ready (no skid buffer).
module bk_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  bk_sub_pipe_if.slave bus
);
  localparam int L = $clog2(WIDTH);

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic acc;

  // A stage may load when it is empty or its content moves on this cycle.
  assign en3          = !v3 || bus.out_ready;
  assign en2          = !v2 || en3;
  assign en1          = !v1 || en2;
  assign bus.in_ready = rst_n && en1;
  assign acc          = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= acc;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  // Stage 1: generate/propagate cells; carry-in of 1 folded into bit 0's generate.
  logic [WIDTH-1:0] g_in, p_in;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_as, s1_bs;

  assign p_in = ~(bus.a ^ bus.b);
  assign g_in = {bus.a[WIDTH-1:1] & ~bus.b[WIDTH-1:1],
                 (bus.a[0] & ~bus.b[0]) | p_in[0]};

  always_ff @(posedge clk) begin
    if (en1) begin
      s1_g  <= g_in;
      s1_p  <= p_in;
      s1_as <= bus.a[WIDTH-1];
      s1_bs <= bus.b[WIDTH-1];
    end
  end

  // Up-sweep: level l combines node i with node i-2^l at every 2^(l+1)-aligned position.
  logic [WIDTH-1:0] ug [0:L];
  logic [WIDTH-1:0] up [0:L];

  assign ug[0] = s1_g;
  assign up[0] = s1_p;

  for (genvar l = 0; l < L; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_node
        assign ug[l+1][i] = ug[l][i] | (up[l][i] & ug[l][i-(2**l)]);
        assign up[l+1][i] = up[l][i] & up[l][i-(2**l)];
      end else begin : g_pass
        assign ug[l+1][i] = ug[l][i];
        assign up[l+1][i] = up[l][i];
      end
    end
  end

  // Stage 2: tree results plus the raw propagate bits still needed for the sum.
  logic [WIDTH-1:0] s2_g;
  logic             s2_p [WIDTH];
  logic [WIDTH-1:0] s2_pr;
  logic             s2_as, s2_bs;

  always_ff @(posedge clk) begin
    if (en2) begin
      s2_g  <= ug[L];
      for (int i = 0; i < WIDTH; i++) s2_p[i] <= up[L][i];
      s2_pr <= s1_p;
      s2_as <= s1_as;
      s2_bs <= s1_bs;
    end
  end

  // Down-sweep: fill the remaining prefixes from the coarsest level down to single bits.
  logic [WIDTH-1:0] dg [0:L-1];

  assign dg[0] = s2_g;

  for (genvar j = 0; j < L - 1; j++) begin : g_dn
    localparam int LV = L - 2 - j;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((((i + 1) % (2 ** (LV + 1))) == (2 ** LV)) && ((i + 1) > (2 ** (LV + 1)))) begin : g_node
        assign dg[j+1][i] = dg[j][i] | (s2_p[i] & dg[j][i-(2**LV)]);
      end else begin : g_pass
        assign dg[j+1][i] = dg[j][i];
      end
    end
  end

  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d_n;
  logic             ovf_n;

  assign c     = dg[L-1];
  assign d_n   = s2_pr ^ {c[WIDTH-2:0], 1'b1};
  assign ovf_n = (s2_as != s2_bs) && (d_n[WIDTH-1] != s2_as);

  // Stage 3: results hold while out_valid is stalled; eq is the full-word group propagate.
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow, r_ovf, r_eq, r_lt_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_eq     <= 1'b0;
      r_lt_s   <= 1'b0;
    end else if (en3 && v2) begin
      r_diff   <= d_n;
      r_borrow <= ~c[WIDTH-1];
      r_ovf    <= ovf_n;
      r_eq     <= s2_p[WIDTH-1];
      r_lt_s   <= d_n[WIDTH-1] ^ ovf_n;
    end
  end

  assign bus.out_valid = v3;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.ovf       = r_ovf;
  assign bus.eq        = r_eq;
  assign bus.lt_s      = r_lt_s;
endmodule

// File: tb/tb_bk_sub_pipe.sv
// Scoreboard bench for bk_sub_pipe at WIDTH=16 and WIDTH=64.
module tb_bk_sub_pipe;
  localparam int NRND = 10000;

  logic clk;
  logic rst_n;

  bk_sub_pipe_if #(.WIDTH(16)) i16();
  bk_sub_pipe_if #(.WIDTH(64)) i64();

  bk_sub_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
  bk_sub_pipe #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64));

  typedef struct packed {
    logic [63:0] diff;
    logic        borrow;
    logic        ovf;
    logic        eq;
    logic        lt_s;
  } exp_t;

  exp_t q16[$];
  exp_t q64[$];
  int   errors = 0;
  int   checks = 0;
  int   pops16 = 0;
  int   pops64 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] m, sb, x, y, d;
    exp_t e;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    sb = 64'd1 << (w - 1);
    x  = ai & m;
    y  = bi & m;
    d  = (x - y) & m;
    e.diff   = d;
    e.borrow = (x < y);
    e.eq     = (x == y);
    e.lt_s   = ((x ^ sb) < (y ^ sb));
    e.ovf    = (((x & sb) != 0) != ((y & sb) != 0)) && (((d & sb) != 0) != ((x & sb) != 0));
    return e;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m, sb, r;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    sb = 64'd1 << (w - 1);
    r  = {$urandom, $urandom};
    case ($urandom % 8)
      0:       return 64'd0;
      1:       return m;
      2:       return sb;
      3:       return sb - 64'd1;
      default: return r & m;
    endcase
  endfunction

  // Output side pops first; a pair accepted this cycle cannot emerge before 3 edges.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q16.delete();
      q64.delete();
    end else begin
      if (i16.out_valid && i16.out_ready) begin
        if (q16.size() == 0) check("w16_unexpected_out", 64'(q16.size()), 64'd1);
        else begin
          e = q16.pop_front();
          check("w16_diff", 64'(i16.diff), e.diff);
          check("w16_borrow", 64'(i16.borrow), 64'(e.borrow));
          check("w16_ovf", 64'(i16.ovf), 64'(e.ovf));
          check("w16_eq", 64'(i16.eq), 64'(e.eq));
          check("w16_lt_s", 64'(i16.lt_s), 64'(e.lt_s));
          pops16++;
        end
      end
      if (i16.in_valid && i16.in_ready) q16.push_back(model(16, 64'(i16.a), 64'(i16.b)));
      if (i64.out_valid && i64.out_ready) begin
        if (q64.size() == 0) check("w64_unexpected_out", 64'(q64.size()), 64'd1);
        else begin
          e = q64.pop_front();
          check("w64_diff", i64.diff, e.diff);
          check("w64_borrow", 64'(i64.borrow), 64'(e.borrow));
          check("w64_ovf", 64'(i64.ovf), 64'(e.ovf));
          check("w64_eq", 64'(i64.eq), 64'(e.eq));
          check("w64_lt_s", 64'(i64.lt_s), 64'(e.lt_s));
          pops64++;
        end
      end
      if (i64.in_valid && i64.in_ready) q64.push_back(model(64, i64.a, i64.b));
    end
  end

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input string tag);
    int lat;
    @(posedge clk); #1;
    i16.in_valid = 1'b1;
    i16.a        = av;
    i16.b        = bv;
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (i16.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check(tag, 64'(lat), 64'd3);
  endtask

  logic [15:0] pa [8];
  logic [15:0] pb [8];
  logic [15:0] held;
  int          idx;
  int          p0;

  initial begin
    rst_n = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.out_ready = 1'b0;
    i64.in_valid = 1'b0; i64.a = '0; i64.b = '0; i64.out_ready = 1'b0;
    held = '0;
    idx  = 0;
    p0   = 0;
    for (int k = 0; k < 8; k++) begin
      pa[k] = 16'($urandom);
      pb[k] = 16'($urandom);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready16", 64'(i16.in_ready), 64'd0);
    check("rst_in_ready64", 64'(i64.in_ready), 64'd0);
    check("rst_out_valid16", 64'(i16.out_valid), 64'd0);
    check("rst_out_valid64", 64'(i64.out_valid), 64'd0);
    check("rst_diff16", 64'(i16.diff), 64'd0);
    check("rst_flags16", 64'({i16.borrow, i16.ovf, i16.eq, i16.lt_s}), 64'd0);
    check("rst_diff64", i64.diff, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready16", 64'(i16.in_ready), 64'd1);
    check("post_rst_in_ready64", 64'(i64.in_ready), 64'd1);

    // Directed arithmetic corners with latency measured from accept.
    i16.out_ready = 1'b1;
    send16(16'h1234, 16'h0234, "lat_basic");
    send16(16'h0000, 16'h0001, "lat_wrap");
    send16(16'hBEEF, 16'hBEEF, "lat_equal");
    send16(16'h8000, 16'h0001, "lat_ovf_neg");
    send16(16'h7FFF, 16'hFFFF, "lat_ovf_pos");

    // Backpressure: 8 pairs offered while the sink stalls for 10 cycles.
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      i16.out_ready = (cyc >= 10);
      i16.in_valid  = (idx < 8);
      if (idx < 8) begin
        i16.a = pa[idx];
        i16.b = pb[idx];
      end
      @(negedge clk); #1;
      if (cyc == 5) held = i16.diff;
      if (cyc == 9) begin
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready", 64'(i16.in_ready), 64'd0);
        check("bp_out_valid", 64'(i16.out_valid), 64'd1);
        check("bp_hold", 64'(i16.diff), 64'(held));
        check("bp_front", 64'(i16.diff), q16[0].diff);
        p0 = pops16;
      end
      if (cyc == 17) check("bp_burst", 64'(pops16 - p0), 64'd8);
      if (i16.in_valid && i16.in_ready) idx++;
    end
    check("bp_all_sent", 64'(idx), 64'd8);
    check("bp_drained", 64'(q16.size()), 64'd0);

    // Reset with two pairs in flight; nothing stale may surface afterwards.
    @(posedge clk); #1;
    i16.out_ready = 1'b1;
    i16.in_valid  = 1'b1;
    i16.a = 16'h1111; i16.b = 16'h0101;
    @(posedge clk); #1;
    i16.a = 16'h2222; i16.b = 16'h0202;
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(i16.in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(i16.out_valid), 64'd0);
    check("midrst_in_ready_after", 64'(i16.in_ready), 64'd1);
    check("midrst_diff", 64'(i16.diff), 64'd0);
    repeat (10) @(posedge clk);

    // Random traffic on both widths concurrently.
    fork
      begin : rnd16
        int  n, g;
        logic take;
        n = 0; g = 0; take = 1'b1;
        while (n < NRND && g < 40000) begin
          @(posedge clk); #1;
          if (take) begin
            i16.a = 16'(rnd_op(16));
            i16.b = 16'(rnd_op(16));
          end
          i16.in_valid  = ($urandom % 4) != 0;
          i16.out_ready = ($urandom % 4) != 0;
          @(negedge clk);
          take = i16.in_valid && i16.in_ready;
          if (take) n++;
          g++;
        end
        @(posedge clk); #1;
        i16.in_valid  = 1'b0;
        i16.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rnd16_sent", 64'(n), 64'(NRND));
        check("rnd16_drained", 64'(q16.size()), 64'd0);
      end
      begin : rnd64
        int  n, g;
        logic take;
        n = 0; g = 0; take = 1'b1;
        while (n < NRND && g < 40000) begin
          @(posedge clk); #1;
          if (take) begin
            i64.a = rnd_op(64);
            i64.b = rnd_op(64);
          end
          i64.in_valid  = ($urandom % 4) != 0;
          i64.out_ready = ($urandom % 4) != 0;
          @(negedge clk);
          take = i64.in_valid && i64.in_ready;
          if (take) n++;
          g++;
        end
        @(posedge clk); #1;
        i64.in_valid  = 1'b0;
        i64.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rnd64_sent", 64'(n), 64'(NRND));
        check("rnd64_drained", 64'(q64.size()), 64'd0);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
